updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised up/down counter with runtime modulus, parallel load, one-shot or
//   wrap mode, registered terminal-count pulse and sticky overflow flag.
//   Next generation of our basic RESET/HOLD/RUN counter.
//   Serves as the generic timebase/event counter for timer and sequencer blocks.
// PARAMETERS
//   WIDTH        8   counter width in bits (>=2)
//   PRESCALE_DIV 4   steps occur every PRESCALE_DIV qualified cycles (PRESCALE_EN only, >=1)
// PORTS
//   clk      in   1      clock, all logic on posedge
//   rst      in   1      synchronous reset, active-high
//   en       in   1      count enable
//   dir      in   1      1 = up, 0 = down
//   oneshot  in   1      1 = stop at terminal (DONE), 0 = wrap
//   load     in   1      parallel load strobe
//   load_val in   WIDTH  value written to count on load
//   max_val  in   WIDTH  runtime modulus top (count range 0..max_val)
//   clr_ovf  in   1      clear sticky ovf
//   count    out  WIDTH  current count (registered)
//   tc       out  1      terminal-count pulse (registered, 1 cycle)
//   ovf      out  1      sticky wrap flag
//   busy     out  1      1 while state == RUN
// BEHAVIOUR
//   Reset: state=IDLE, count=0, tc=0, ovf=0, busy=0, prescaler=0.
//   FSM (state registered, transitions on posedge):
//     IDLE: en -> RUN, else -> HOLD.   HOLD: en -> RUN.
//     RUN : !en -> HOLD; terminal step with oneshot=1 -> DONE.
//     DONE: holds count; leaves only via load (-> HOLD) or rst.
//   Step: occurs in a cycle where state==RUN, en==1, tick==1, load==0.
//     tick = 1 every cycle when PRESCALE_EN is undefined.
//   Terminal condition: up: count >= max_val; down: count == 0.
//   Non-terminal step: up count+1, down count-1 (modulo 2^WIDTH never reached).
//   Terminal step, oneshot=0: up -> 0, down -> max_val; tc=1 next cycle; ovf set.
//   Terminal step, oneshot=1: count unchanged; tc=1 next cycle; state -> DONE; ovf unchanged.
//   tc: 1 only in the cycle after a terminal step, else 0; never 2 cycles unless
//     consecutive terminal steps (e.g. max_val=0).
//   max_val=0: every step is terminal; count stays 0 and tc pulses each step.
//   max_val lowered below count while counting up: next step is terminal, wraps to 0.
//   load: priority below rst, above stepping; count<=load_val, no step that cycle,
//     tc=0; DONE -> HOLD, other states unchanged; load_val>max_val allowed.
//   ovf: set by wrap, cleared by clr_ovf; simultaneous set and clear -> set wins.
//   dir/oneshot/max_val sampled every step; changes take effect on the next step.
//   rst mid-run: all state returns to reset values on the next edge, no tc pulse.
//   busy = (state == RUN), registered with state.
// CONFIGURATION
//   UPDOWN_MOD_COUNTER_PRESCALE_EN defined: internal prescaler, $clog2(PRESCALE_DIV)+1
//     bits, counts cycles with state==RUN && en; tick=1 when prescaler==PRESCALE_DIV-1,
//     then prescaler wraps to 0; prescaler cleared on rst, load, and whenever
//     state!=RUN or en==0.
//   Undefined: no prescaler logic; tick tied to 1; PRESCALE_DIV ignored.
// TESTING
//   1. rst, en=1, dir=1, oneshot=0, max_val=5, 8 steps -> count 0,1..5,0,1; tc=1 with
//      count=0; ovf=1.
//   2. load_val=3, load, dir=0, oneshot=1, en=1 -> 3,2,1,0, hold 0; tc once; state DONE;
//      en toggling no effect; load -> HOLD.
//   3. en dropped at count=2 for 4 cycles -> count holds 2, busy=0; en=1 resumes at 3.
//   4. max_val=0, up, wrap -> count stays 0, tc=1 every step; max_val 9->4 at count=7
//      -> next count 0, tc=1.
//   5. wrap and clr_ovf in the same cycle -> ovf=1; clr_ovf alone -> ovf=0;
//      rst mid-count -> count=0, tc=0, ovf=0, state IDLE.
//   6. PRESCALE_EN, PRESCALE_DIV=4, max_val=2, up -> count changes every 4th cycle;
//      load mid-period restarts prescaler.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down counter with runtime modulus, parallel load, one-shot/wrap modes, tc pulse and sticky ovf.
// Optional prescaler enabled by defining UPDOWN_MOD_COUNTER_PRESCALE_EN.
module updown_mod_counter #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   tick;
  logic   step;
  logic   terminal;

  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             up,
    input logic             stop_at_term,
    input logic             at_term,
    input logic [WIDTH-1:0] top
  );
    if (at_term)
      return stop_at_term ? cur : (up ? '0 : top);
    return up ? cur + 1'b1 : cur - 1'b1;
  endfunction

`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE_DIV) + 1;

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(PRESCALE_DIV - 1));

  // Prescaler only advances across consecutive enabled RUN cycles.
  always_ff @(posedge clk) begin
    if (rst || load || (state != RUN) || !en)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end
`else
  logic unused_prescale_div;

  assign unused_prescale_div = |PRESCALE_DIV;
  assign tick = 1'b1;
`endif

  assign terminal = dir ? (count >= max_val) : (count == '0);
  assign step     = (state == RUN) && en && tick && !load;

  always_comb begin
    state_nxt = state;
    if (load) begin
      if (state == DONE)
        state_nxt = HOLD;
    end else begin
      case (state)
        IDLE:    state_nxt = en ? RUN : HOLD;
        HOLD:    state_nxt = en ? RUN : HOLD;
        RUN: begin
          if (!en)
            state_nxt = HOLD;
          else if (step && terminal && oneshot)
            state_nxt = DONE;
        end
        default: state_nxt = DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      tc    <= step && terminal;
      // A wrap in the same cycle as a clear leaves the flag set.
      if (step && terminal && !oneshot)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
      if (load)
        count <= load_val;
      else if (step)
        count <= next_count(count, dir, oneshot, terminal, max_val);
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized and directed bench for updown_mod_counter against a behavioural model.
// Define UPDOWN_MOD_COUNTER_PRESCALE_EN for both files to exercise the prescaler.
module tb_updown_mod_counter;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int S_IDLE = 0, S_HOLD = 1, S_RUN = 2, S_DONE = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, dir = 1'b1, oneshot = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [W-1:0] load_val = '0, max_val = '0;
  logic [W-1:0] count;
  logic         tc, ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int m_count = 0, m_state = S_IDLE, m_presc = 0;
  bit m_tc = 0, m_ovf = 0;

  updown_mod_counter #(.WIDTH(W), .PRESCALE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .oneshot(oneshot), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(count), .tc(tc), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: advance one clock using the inputs currently applied.
  task automatic model_edge();
    bit tk, st, term;
    int nstate;
    if (rst) begin
      m_count = 0; m_tc = 0; m_ovf = 0; m_state = S_IDLE; m_presc = 0;
      return;
    end
`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
    tk = (m_presc == DIV - 1);
`else
    tk = 1;
`endif
    st   = (m_state == S_RUN) && en && tk && !load;
    term = dir ? (m_count >= int'(max_val)) : (m_count == 0);
    if (load || m_state != S_RUN || !en) m_presc = 0;
    else m_presc = (m_presc + 1) % DIV;
    nstate = m_state;
    if (load) begin
      if (m_state == S_DONE) nstate = S_HOLD;
    end else if (m_state == S_IDLE || m_state == S_HOLD) begin
      nstate = en ? S_RUN : S_HOLD;
    end else if (m_state == S_RUN) begin
      if (!en) nstate = S_HOLD;
      else if (st && term && oneshot) nstate = S_DONE;
    end
    m_tc = st && term;
    if (st && term && !oneshot) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    if (load) m_count = int'(load_val);
    else if (st) begin
      if (!term) m_count = dir ? m_count + 1 : m_count - 1;
      else if (!oneshot) m_count = dir ? 0 : int'(max_val);
    end
    m_state = nstate;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+2:0] exp_vec();
    return {W'(m_count), m_tc, m_ovf, (m_state == S_RUN)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    cyc(); cyc();
    n_checks++;
    if ({count, tc, ovf, busy} !== {W'(0), 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got count=%0d tc=%b ovf=%b busy=%b, want 0 0 0 0", count, tc, ovf, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    int exp_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    en = 1'b1; dir = 1'b1; oneshot = 1'b0; max_val = 8'd5;
    cyc();
    n_checks++;
    if ({count, busy} !== {W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_start: got count=%0d busy=%b, want 0 1", count, busy);
    end
    for (int i = 0; i < 7; i++) begin
      cyc();
      n_checks++;
      if ({count, tc, ovf, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_model[%0d]: got %h, want %h", i, {count, tc, ovf, busy}, exp_vec());
      end
`ifndef UPDOWN_MOD_COUNTER_PRESCALE_EN
      n_checks++;
      if (count !== W'(exp_seq[i]) || tc !== (i == 5)) begin
        n_fail++;
        $display("FAIL wrap_seq[%0d]: got count=%0d tc=%b, want %0d %b", i, count, tc, exp_seq[i], i == 5);
      end
`endif
    end
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ovf: got %b, want 1", ovf);
    end
  endtask

  task automatic test_oneshot_down();
    int tc_cnt = 0;
    load_val = 8'd3; load = 1'b1; dir = 1'b0; oneshot = 1'b1; en = 1'b1;
    cyc();
    load = 1'b0;
    n_checks++;
    if ({count, tc} !== {W'(3), 1'b0}) begin
      n_fail++;
      $display("FAIL oneshot_load: got count=%0d tc=%b, want 3 0", count, tc);
    end
    for (int i = 0; i < 28; i++) begin
      cyc();
      tc_cnt += int'(tc);
      n_checks++;
      if ({count, tc, ovf, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL oneshot_model[%0d]: got %h, want %h", i, {count, tc, ovf, busy}, exp_vec());
      end
    end
    n_checks++;
    if (tc_cnt !== 1 || count !== W'(0) || busy !== 1'b0 || m_state != S_DONE) begin
      n_fail++;
      $display("FAIL oneshot_done: got tc_pulses=%0d count=%0d busy=%b, want 1 0 0", tc_cnt, count, busy);
    end
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom_range(0, 1));
      cyc();
      n_checks++;
      if ({count, tc, busy} !== {W'(0), 2'b00}) begin
        n_fail++;
        $display("FAIL done_hold[%0d]: got count=%0d tc=%b busy=%b, want 0 0 0", i, count, tc, busy);
      end
    end
    en = 1'b0; load = 1'b1; load_val = 8'd0;
    cyc();
    load = 1'b0;
    n_checks++;
    if (m_state != S_HOLD || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_load: got busy=%b, want 0 with state HOLD", busy);
    end
  endtask

  task automatic test_pause();
    dir = 1'b1; oneshot = 1'b0; max_val = 8'd9; en = 1'b1;
    while (m_count != 2) begin
      cyc();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if ({count, busy} !== {W'(2), 1'b0}) begin
        n_fail++;
        $display("FAIL pause[%0d]: got count=%0d busy=%b, want 2 0", i, count, busy);
      end
    end
    en = 1'b1;
    while (m_count == 2) begin
      cyc();
    end
    n_checks++;
    if ({count, busy} !== {W'(3), 1'b1}) begin
      n_fail++;
      $display("FAIL resume: got count=%0d busy=%b, want 3 1", count, busy);
    end
  endtask

  task automatic test_max_zero();
    int steps = 0;
    max_val = 8'd0; dir = 1'b1; oneshot = 1'b0; en = 1'b1;
    load = 1'b1; load_val = 8'd0;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      n_checks++;
      if ({count, tc, ovf, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL maxzero_model[%0d]: got %h, want %h", i, {count, tc, ovf, busy}, exp_vec());
      end
      steps += int'(tc);
      if (count !== W'(0)) begin
        n_checks++; n_fail++;
        $display("FAIL maxzero_count[%0d]: got %0d, want 0", i, count);
      end
    end
`ifndef UPDOWN_MOD_COUNTER_PRESCALE_EN
    n_checks++;
    if (steps != 16) begin
      n_fail++;
      $display("FAIL maxzero_tc: got %0d pulses, want 16", steps);
    end
`endif
    max_val = 8'd9;
    while (m_count != 7) begin
      cyc();
    end
    max_val = 8'd4;
    while (m_count == 7) begin
      cyc();
    end
    n_checks++;
    if ({count, tc} !== {W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL max_lowered: got count=%0d tc=%b, want 0 1", count, tc);
    end
  endtask

  task automatic test_ovf_and_rst();
    dir = 1'b1; oneshot = 1'b0; max_val = 8'd3; en = 1'b1; clr_ovf = 1'b1;
    cyc();
    while (m_ovf) cyc();
    while (!m_tc) begin
      clr_ovf = (m_count == 3) ? 1'b1 : 1'b0;
      cyc();
    end
    clr_ovf = 1'b0;
    n_checks++;
    if ({tc, ovf} !== 2'b11) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got tc=%b ovf=%b, want 1 1", tc, ovf);
    end
    clr_ovf = 1'b1; en = 1'b0;
    cyc();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, want 0", ovf);
    end
    en = 1'b1; max_val = 8'd1;
    while (!m_tc) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({count, tc, ovf, busy} !== {W'(0), 3'b000} || m_state != S_IDLE) begin
      n_fail++;
      $display("FAIL rst_mid: got count=%0d tc=%b ovf=%b busy=%b, want 0 0 0 0", count, tc, ovf, busy);
    end
  endtask

`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    int last, gap;
    rst = 1'b1; cyc(); rst = 1'b0;
    dir = 1'b1; oneshot = 1'b0; max_val = 8'd2; en = 1'b1;
    cyc();
    last = int'(count); gap = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      gap++;
      if (int'(count) != last) begin
        n_checks++;
        if (gap != DIV) begin
          n_fail++;
          $display("FAIL prescale_gap: got %0d cycles, want %0d", gap, DIV);
        end
        gap = 0; last = int'(count);
      end
    end
    for (int i = 0; i < 2; i++) cyc();
    load = 1'b1; load_val = 8'd1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      cyc();
      n_checks++;
      if (count !== ((i == DIV - 1) ? W'(2) : W'(1))) begin
        n_fail++;
        $display("FAIL prescale_load[%0d]: got %0d, want %0d", i, count, (i == DIV - 1) ? 2 : 1);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      en       = ($urandom_range(0, 9) < 8);
      dir      = 1'($urandom_range(0, 1));
      oneshot  = ($urandom_range(0, 3) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, 15));
      clr_ovf  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) max_val = W'($urandom_range(0, 12));
      cyc();
      n_checks++;
      if ({count, tc, ovf, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got count=%0d tc=%b ovf=%b busy=%b, want %h", i, count, tc, ovf, busy, exp_vec());
      end
    end
    rst = 1'b0; load = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_oneshot_down();
    test_pause();
    test_max_zero();
    test_ovf_and_rst();
`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
